// File: rtl/mvu_pkg.sv
// Shared constants and types for the MVU CSR APB responder.
// The CSR-side request struct mirrors the csr_* output bundle.
package mvu_pkg;
   localparam int APB_ADDR_WIDTH = 15;
   localparam int APB_DATA_WIDTH = 32;
   localparam int APB_STRB_WIDTH = 4;
   localparam int BMVUA          = 3;
   localparam int BCSRA          = 12;

   typedef logic [BCSRA-1:0] mvu_csr_t;

   localparam mvu_csr_t CSR_FIRST     = 12'hf20;
   localparam mvu_csr_t CSR_LAST      = 12'hf69;
   localparam mvu_csr_t CSR_MVUSTATUS = 12'hf54;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [BMVUA-1:0]          mvu;
      mvu_csr_t                  addr;
      logic                      we;
      logic [APB_DATA_WIDTH-1:0] wdata;
      logic [APB_STRB_WIDTH-1:0] wstrb;
   } csr_req_t;
endpackage

// File: rtl/mvu_csr_decode.sv
// Combinational CSR number check: out-of-window and read-only targets.
module mvu_csr_decode
   import mvu_pkg::*;
(
   input  logic [BCSRA-1:0] addr,
   output logic             range_err,
   output logic             ro_err
);
   assign range_err = (addr < CSR_FIRST) || (addr > CSR_LAST);
   assign ro_err    = (addr == CSR_MVUSTATUS);
endmodule

// File: rtl/mvu_apb_responder.sv
// APB slave that forwards CSR accesses to the MVU CSR port and waits for ack,
// bounded by TIMEOUT cycles; decode errors are answered without touching the CSR side.
module mvu_apb_responder
   import mvu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [APB_ADDR_WIDTH-1:0] paddr,
   input  logic [APB_DATA_WIDTH-1:0] pwdata,
   input  logic [APB_STRB_WIDTH-1:0] pstrb,
   output logic [31:0]               prdata,
   output logic                      pready,
   output logic                      pslverr,
   output logic                      csr_req,
   output logic [BMVUA-1:0]          csr_mvu,
   output logic [BCSRA-1:0]          csr_addr,
   output logic                      csr_we,
   output logic [31:0]               csr_wdata,
   output logic [3:0]                csr_wstrb,
   input  logic                      csr_ack,
   input  logic [31:0]               csr_rdata
);
   localparam int             CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   csr_req_t      req_q;
   logic [CW-1:0] wait_cnt;
   logic          err_q;
   logic          range_err, ro_err, dec_err, start, timeout;

   // Decode the live address so the IDLE->REQ/RESP choice is made on the same edge
   // that captures the transfer.
   mvu_csr_decode u_dec (
      .addr      (paddr[BCSRA-1:0]),
      .range_err (range_err),
      .ro_err    (ro_err)
   );

   assign start   = psel && penable;
   assign dec_err = range_err || (pwrite && ro_err);
   assign timeout = (wait_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = dec_err ? ST_RESP : ST_REQ;
         ST_REQ:  if (csr_ack || timeout) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pready  = (state_q == ST_RESP);
      pslverr = (state_q == ST_RESP) && err_q;
   end

   // An ack in the last allowed cycle still wins over the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q    <= '0;
         csr_req  <= 1'b0;
         wait_cnt <= '0;
         err_q    <= 1'b0;
         prdata   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               wait_cnt <= '0;
               if (start) begin
                  err_q <= dec_err;
                  if (dec_err) begin
                     prdata <= '0;
                  end else begin
                     req_q.mvu   <= paddr[APB_ADDR_WIDTH-1:BCSRA];
                     req_q.addr  <= paddr[BCSRA-1:0];
                     req_q.we    <= pwrite;
                     req_q.wdata <= pwdata;
                     req_q.wstrb <= pstrb;
                     csr_req     <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (csr_ack) begin
                  csr_req <= 1'b0;
                  prdata  <= req_q.we ? '0 : csr_rdata;
               end else if (timeout) begin
                  csr_req <= 1'b0;
                  err_q   <= 1'b1;
                  prdata  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign csr_mvu   = req_q.mvu;
   assign csr_addr  = req_q.addr;
   assign csr_we    = req_q.we;
   assign csr_wdata = req_q.wdata;
   assign csr_wstrb = req_q.wstrb;
endmodule

// File: tb/tb_mvu_apb_responder.sv
// Scoreboard bench: the APB driver queues expected responses and CSR requests,
// negedge monitors pop and compare them when pready / csr_req appear.
module tb_mvu_apb_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [14:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        csr_req;
   logic [2:0]  csr_mvu;
   logic [11:0] csr_addr;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic [3:0]  csr_wstrb;
   logic        csr_ack;
   logic [31:0] csr_rdata;

   mvu_apb_responder #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
      .pready(pready), .pslverr(pslverr), .csr_req(csr_req), .csr_mvu(csr_mvu),
      .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
      .csr_wstrb(csr_wstrb), .csr_ack(csr_ack), .csr_rdata(csr_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          t_ready;
   } resp_t;

   typedef struct {
      logic [2:0]  mvu;
      logic [11:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          len;
   } creq_t;

   resp_t resp_q[$];
   creq_t csr_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc      = 0;
   int    ack_dly  = -1;
   logic [31:0] ack_data = '0;
   bit    stray = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endfunction

   // CSR-side responder: acks ack_dly cycles after csr_req rises, or a forced stray pulse
   int rcnt = 0;
   always @(negedge clk) begin
      if (stray) begin
         csr_ack = 1'b1; csr_rdata = 32'hFFFF_FFFF;
      end else if (csr_req && rcnt == ack_dly) begin
         csr_ack = 1'b1; csr_rdata = ack_data;
      end else begin
         csr_ack = 1'b0; csr_rdata = 32'hDEAD_0000;
      end
      rcnt = csr_req ? rcnt + 1 : 0;
   end

   // Monitor
   bit    req_prev = 1'b0;
   int    req_len  = 0;
   creq_t cur;
   always @(negedge clk) begin
      resp_t e;
      if (pready) begin
         if (resp_q.size() == 0) chk("pready_unexpected", 32'(pready), 32'd0);
         else begin
            e = resp_q.pop_front();
            chk("prdata", prdata, e.rdata);
            chk("pslverr", 32'(pslverr), 32'(e.err));
            chk("latency", cyc, e.t_ready);
         end
      end
      if (csr_req && !req_prev) begin
         if (csr_q.size() == 0) chk("csr_req_unexpected", 32'(csr_req), 32'd0);
         else begin
            cur = csr_q.pop_front();
            chk("csr_mvu", 32'(csr_mvu), 32'(cur.mvu));
            chk("csr_addr", 32'(csr_addr), 32'(cur.addr));
            chk("csr_we", 32'(csr_we), 32'(cur.we));
            chk("csr_wdata", csr_wdata, cur.wdata);
            chk("csr_wstrb", 32'(csr_wstrb), 32'(cur.wstrb));
         end
         req_len = 1;
      end else if (csr_req) begin
         req_len++;
         chk("csr_hold", {csr_mvu, csr_addr, csr_we, csr_wstrb}, {12'b0, cur.mvu, cur.addr, cur.we, cur.wstrb});
      end
      if (!csr_req && req_prev) chk("csr_req_len", req_len, cur.len);
      req_prev = csr_req;
   end

   // exp_len: expected csr_req high cycles, 0 when the CSR side must stay quiet
   task automatic apb_xfer(input bit wr, input logic [14:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int dly, input logic [31:0] rd,
                           input logic [31:0] exp_rdata, input bit exp_err,
                           input int exp_lat, input int exp_len);
      int n;
      @(negedge clk);
      psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
      ack_dly = dly; ack_data = rd;
      @(negedge clk);
      penable = 1;
      if (exp_len > 0) csr_q.push_back('{addr[14:12], addr[11:0], wr, wd, st, exp_len});
      resp_q.push_back('{exp_rdata, exp_err, cyc + exp_lat});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pready && n < 40);
      if (!pready) chk("pready_timeout", 32'(pready), 32'd1);
      psel = 0; penable = 0;
      ack_dly = -1;
   endtask

   initial begin
      rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
      repeat (3) @(negedge clk);
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_pready", 32'(pready), 32'd0);
      chk("rst_pslverr", 32'(pslverr), 32'd0);
      chk("rst_csr_req", 32'(csr_req), 32'd0);
      chk("rst_csr_bus", {csr_mvu, csr_addr, csr_we, csr_wstrb}, 32'd0);
      chk("rst_csr_wdata", csr_wdata, 32'd0);
      rst = 0;

      //        wr  addr      wdata          strb  dly  csr_rdata      exp_rdata      err lat len
      apb_xfer(1, 15'h2f20, 32'h0000_0123, 4'hf, 1,  32'h0,         32'h0,         0,  3,  2);
      apb_xfer(0, 15'h0f54, 32'h0,         4'h0, 0,  32'hA5A5_0001, 32'hA5A5_0001, 0,  2,  1);
      apb_xfer(0, 15'h7f69, 32'h0,         4'h0, -1, 32'h0,         32'h0,         1,  17, 16);
      apb_xfer(1, 15'h0f54, 32'h0000_BEEF, 4'hf, 0,  32'h0,         32'h0,         1,  1,  0);
      apb_xfer(0, 15'h3f6a, 32'h0,         4'h0, 0,  32'h0,         32'h0,         1,  1,  0);
      apb_xfer(0, 15'h4f20, 32'h0,         4'h0, 2,  32'h1234_5678, 32'h1234_5678, 0,  4,  3);
      apb_xfer(0, 15'h0100, 32'h0,         4'h0, 0,  32'h0,         32'h0,         1,  1,  0);
      apb_xfer(0, 15'h5f1f, 32'h0,         4'h0, 0,  32'h0,         32'h0,         1,  1,  0);
      apb_xfer(1, 15'h6f69, 32'hDEAD_BEEF, 4'h5, 0,  32'h0,         32'h0,         0,  2,  1);

      // reset during the third REQ cycle of a write
      @(negedge clk);
      psel = 1; penable = 0; pwrite = 1; paddr = 15'h1f30; pwdata = 32'h77; pstrb = 4'hf;
      ack_dly = -1;
      @(negedge clk);
      penable = 1;
      csr_q.push_back('{3'd1, 12'hf30, 1'b1, 32'h77, 4'hf, 3});
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("rst_mid_csr_req", 32'(csr_req), 32'd0);
      chk("rst_mid_pready", 32'(pready), 32'd0);
      chk("rst_mid_csr_addr", {csr_mvu, csr_addr, csr_we}, 32'd0);
      psel = 0; penable = 0; rst = 0;

      apb_xfer(1, 15'h1f55, 32'h0000_CAFE, 4'h3, 0,  32'h0,         32'h0,         0,  2,  1);

      // back-to-back reads with a stray ack in IDLE between them
      apb_xfer(0, 15'h0f21, 32'h0,         4'h0, 0,  32'h1111_1111, 32'h1111_1111, 0,  2,  1);
      @(negedge clk);
      stray = 1;
      repeat (2) @(negedge clk);
      stray = 0;
      @(negedge clk);
      chk("stray_prdata", prdata, 32'h1111_1111);
      chk("stray_csr_req", 32'(csr_req), 32'd0);
      apb_xfer(0, 15'h0f22, 32'h0,         4'h0, 1,  32'h2222_2222, 32'h2222_2222, 0,  3,  2);

      repeat (4) @(negedge clk);
      chk("resp_q_drained", resp_q.size(), 32'd0);
      chk("csr_q_drained", csr_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
